// File: rtl/strip_pkg.sv
// Shared definitions for the strip frame readout path: frame width, header codes,
// controller state encoding and a constant-evaluable ceil(log2) helper.
// No ports; imported by the arbiter, its round-robin sub-block and the bus interface.
package strip_pkg;

   localparam int FRAME_W = 104;

   localparam logic [3:0] HDR_DATA = 4'b1010;
   localparam logic [3:0] HDR_SYNC = 4'b1100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/strip_frame_arbiter_if.sv
// Channel-side strobes and the shared valid/ready readout bus of the strip arbiter.
// Ports: ch_valid/ch_frame (per-channel frame strobes), out_valid/out_ready/out_frame/out_ch.
// slave = the arbiter; master = the side driving channels and consuming the readout.
interface strip_frame_arbiter_if #(
   parameter int N_CH    = 4,
   parameter int FRAME_W = strip_pkg::FRAME_W
);
   logic [N_CH-1:0]                    ch_valid;
   logic [N_CH*FRAME_W-1:0]            ch_frame;
   logic                               out_valid;
   logic                               out_ready;
   logic [FRAME_W-1:0]                 out_frame;
   logic [strip_pkg::clog2(N_CH)-1:0]  out_ch;

   modport slave (
      input  ch_valid, ch_frame, out_ready,
      output out_valid, out_frame, out_ch
   );

   modport master (
      output ch_valid, ch_frame, out_ready,
      input  out_valid, out_frame, out_ch
   );
endinterface

// File: rtl/strip_frame_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr_i, ascending with wrap.
// Combinational, zero latency; no backpressure of its own.
// Ports: req_i (requests), ptr_i (start position), gnt_o (one-hot), idx_o (index), vld_o (any grant).
module rr_arbiter
   import strip_pkg::*;
#(
   parameter int N = 4,
   parameter int W = clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o,
   output logic         vld_o
);

   logic         found;
   logic [W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = W'((int'(ptr_i) + k) % N);
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            gnt_o[cand]  = 1'b1;
            idx_o        = cand;
         end
      end
      vld_o = found;
   end

endmodule

// File: rtl/strip_frame_arbiter.sv
// Buffers one strip frame per channel and shares one readout bus round-robin.
// Latency: strobe at edge t -> holder full -> out_valid after edge t+1 (if slot free and won).
// Backpressure: out_ready low freezes the output; a strobe into a still-full holder is dropped and counted.
// Ports: clk160/reset_n, enable (run/flush), bus (channel strobes + readout), drop_cnt/drop_cnt_clr,
//        state (0 IDLE, 1 RUN, 2 FLUSH), busy (any holder or output occupied).
module strip_frame_arbiter
   import strip_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk160,
   input  logic                     reset_n,
   input  logic                     enable,
   strip_frame_arbiter_if.slave     bus,
   output logic [N_CH*CNT_W-1:0]    drop_cnt,
   input  logic                     drop_cnt_clr,
   output logic [1:0]               state,
   output logic                     busy
);

   localparam int CH_W = clog2(N_CH);

   state_t              state_q;
   logic [N_CH-1:0]     full_q, full_d;
   logic [FRAME_W-1:0]  hold_q [N_CH];
   logic [CH_W-1:0]     ptr_q;
   logic                out_valid_q;
   logic [FRAME_W-1:0]  out_frame_q;
   logic [CH_W-1:0]     out_ch_q;
   logic [CNT_W-1:0]    cnt_q [N_CH];

   logic                slot_free, gnt_any, gnt_en;
   logic [N_CH-1:0]     req, gnt, cap, drop;
   logic [CH_W-1:0]     gnt_idx;

   // Output slot frees up in the same cycle the current frame is accepted,
   // which is what allows one frame per cycle.
   assign slot_free = !out_valid_q || bus.out_ready;
   assign req       = (state_q == IDLE) ? '0 : full_q;
   assign gnt_en    = slot_free && gnt_any;

   rr_arbiter #(.N(N_CH), .W(CH_W)) u_rr (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .vld_o (gnt_any)
   );

   // A holder being granted this cycle may take a new frame at the same edge.
   always_comb begin
      cap    = '0;
      drop   = '0;
      full_d = full_q;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt_en && gnt[i]) full_d[i] = 1'b0;
         if (state_q == RUN && bus.ch_valid[i]) begin
            if (!full_q[i] || (gnt_en && gnt[i])) begin
               cap[i]    = 1'b1;
               full_d[i] = 1'b1;
            end else begin
               drop[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk160 or negedge reset_n) begin
      if (!reset_n) begin
         full_q <= '0;
         for (int i = 0; i < N_CH; i++) begin
            hold_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         full_q <= full_d;
         for (int i = 0; i < N_CH; i++) begin
            if (cap[i]) hold_q[i] <= bus.ch_frame[i*FRAME_W +: FRAME_W];
            // Clear wins over a same-cycle drop.
            if (drop_cnt_clr)                  cnt_q[i] <= '0;
            else if (drop[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   // Output register and round-robin pointer; frame/channel only change on a grant,
   // so they stay stable while a presented frame is stalled.
   always_ff @(posedge clk160 or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_frame_q <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else if (gnt_en) begin
         out_valid_q <= 1'b1;
         out_frame_q <= hold_q[gnt_idx];
         out_ch_q    <= gnt_idx;
         ptr_q       <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk160 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (enable) state_q <= RUN;
            RUN:     if (!enable) state_q <= FLUSH;
            FLUSH: begin
               if (enable)                              state_q <= RUN;
               else if (full_q == '0 && !out_valid_q)   state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      drop_cnt = '0;
      for (int i = 0; i < N_CH; i++) drop_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_frame = out_frame_q;
   assign bus.out_ch    = out_ch_q;
   assign state         = state_q;
   assign busy          = (|full_q) || out_valid_q;

endmodule

// File: doc/strip_frame_arbiter.md
Name: strip_frame_arbiter

Overview:
Shares one 104-bit strip frame readout path between N strip checker channels. Each channel delivers a frame as a one-cycle valid pulse with its assembled frame. The block buffers one frame per channel, picks channels round-robin, and presents one frame at a time on a valid/ready output. It counts frames dropped per channel and supports run/flush sequencing. It sits between the per-channel strip frame assemblers and the shared readout FIFO/ILA, all in the clk160 domain.

Parameters:
N_CH, 4, number of strip channels (2..8)
FRAME_W, 104, frame width (4 x 26-bit payload words)
CNT_W, 8, width of each per-channel drop counter

Ports:
clk160  in  1  system clock, 160 MHz
reset_n  in  1  asynchronous active-low reset
enable  in  1  run request; deassert to flush and stop
ch_valid  in  N_CH  per-channel one-cycle frame strobe
ch_frame  in  N_CH*FRAME_W  channel i frame on bits [i*FRAME_W +: FRAME_W]
out_valid  out  1  output frame valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_frame  out  FRAME_W  granted frame
out_ch  out  clog2(N_CH)  source channel of out_frame
drop_cnt  out  N_CH*CNT_W  saturating per-channel drop counters
drop_cnt_clr  in  1  synchronous clear of all drop counters
state  out  2  controller state: 0 IDLE, 1 RUN, 2 FLUSH
busy  out  1  high when any holding register or the output is occupied

Behaviour:
- Clock and reset: one clock, clk160. reset_n is asynchronous and active-low.
- Reset values: state=IDLE; all holding registers empty; out_valid=0; out_frame=0; out_ch=0; drop_cnt=0; round-robin pointer=0; busy=0. Reset mid-transfer discards every held and presented frame with no handshake.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> FLUSH when enable=0.
  - FLUSH -> IDLE when all holders are empty and out_valid=0.
  - FLUSH -> RUN when enable=1 again.
- Capture: in RUN only, ch_valid[i] writes ch_frame slice i into holder i if the holder is empty, or if the holder is being granted in the same cycle.
  - ch_valid in IDLE or FLUSH is ignored. It is not counted as a drop.
- Drop: in RUN, ch_valid[i] while holder i stays full (not granted this cycle) drops the new frame and keeps the old one. drop_cnt[i] increments and saturates at all-ones.
  - drop_cnt_clr has priority over a same-cycle increment; result is 0.
- Grant: the output slot is free when out_valid=0 or (out_valid & out_ready).
  - When free and at least one holder is full (RUN or FLUSH), grant the first full holder at or after the pointer, in ascending order with wrap from N_CH-1 to 0.
  - The pointer then becomes granted+1 mod N_CH. With no grant, the pointer holds.
- Output register: the grant loads out_frame/out_ch and sets out_valid=1 on the next edge.
  - out_frame and out_ch must stay stable while out_valid=1 and out_ready=0.
  - out_valid clears after acceptance when no new grant occurs.
  - Back-to-back frames are allowed: one frame per cycle at full throughput.
- Latency: ch_valid at edge t -> holder full after t -> out_valid=1 after edge t+1, when the slot is free and the channel wins arbitration.
- busy = OR of holder-full flags, OR out_valid.
- ch_valid X/unknown after reset is not required to be handled.

Decomposition:
- Shared package strip_pkg: FRAME_W=104, the header codes HDR_DATA=4'b1010 and HDR_SYNC=4'b1100, the state encodings IDLE/RUN/FLUSH, and the clog2 helper.
- Sub-module rr_arbiter: N-bit request vector plus pointer -> one-hot grant and an index. Combinational, reused by other readout muxes.
- The holders, FSM and drop counters stay in the top level.

Test Plan:
1. Reset then enable=1; single ch_valid[2] with frame 104'hA5...: out_valid rises two edges later, out_ch=2, out_frame matches; out_ready=1 -> busy=0 next cycle.
2. All four channels strobe in the same cycle, out_ready=1, pointer=0: grants arrive in order ch0, ch1, ch2, ch3 on consecutive cycles; no drops.
3. out_ready=0; ch1 strobes three times: first frame presented and held stable, second buffered, third dropped -> drop_cnt[1]=1; release ready -> frames 1 and 2 delivered in order.
4. Hold out_ready=0 with ch0 strobing 300 times: drop_cnt[0] saturates at 255. Pulse drop_cnt_clr together with a new drop: counter reads 0.
5. Two frames pending, enable=0: state=FLUSH, further ch_valid ignored with no drop count; both frames drain, then state=IDLE and busy=0.
6. Assert reset_n low while out_valid=1 and out_ready=0: out_valid=0, drop_cnt=0 and state=IDLE immediately, without waiting for a clock edge.
